// File: rtl/audio_volume.sv
// Stereo volume stage: scales signed L/R samples by a gain that ramps toward its target once per sample.
// Optional peak meters are built when AUDIO_VOLUME_PEAK_EN is defined.
module audio_volume #(
  parameter int DATA_BIT  = 24,
  parameter int GAIN_BIT  = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [DATA_BIT-1:0] i_audio_l,
  input  logic [DATA_BIT-1:0] i_audio_r,
  input  logic                i_audio_valid,
  input  logic [GAIN_BIT-1:0] i_gain,
  input  logic                i_mute,
  input  logic                i_peak_clr,
  output logic [DATA_BIT-1:0] o_audio_l,
  output logic [DATA_BIT-1:0] o_audio_r,
  output logic                o_audio_valid,
  output logic [GAIN_BIT-1:0] o_gain,
  output logic                o_muted,
  output logic                o_overrun,
  output logic [DATA_BIT-2:0] o_peak_l,
  output logic [DATA_BIT-2:0] o_peak_r,
  output logic [1:0]          o_dbg_state
);

  localparam int PW = DATA_BIT + GAIN_BIT + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_BIT+1){1'b0}}, {(DATA_BIT-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [GAIN_BIT-1:0]  STEP_G  = GAIN_BIT'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL_L = 2'd1,
    S_MUL_R = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BIT-1:0]        l_q, r_q;
  logic [GAIN_BIT-1:0]        g_cap_q;
  logic [GAIN_BIT-1:0]        g_q, g_d;
  logic signed [PW-1:0]       p_l_q;
  logic [DATA_BIT-1:0]        out_l_q, out_r_q;
  logic                       overrun_q;

  logic                       accept;
  logic                       drop;
  logic signed [DATA_BIT-1:0] mul_op;
  logic signed [GAIN_BIT:0]   g_ext;
  logic signed [PW-1:0]       prod;
  logic [GAIN_BIT-1:0]        target;
  logic [GAIN_BIT-1:0]        diff;

  // Shift back to sample scale (floor) and clamp to the sample range.
  function automatic logic [DATA_BIT-1:0] sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] y;
    y = p >>> (GAIN_BIT - 1);
    if (y > SAT_MAX) y = SAT_MAX;
    else if (y < SAT_MIN) y = SAT_MIN;
    return y[DATA_BIT-1:0];
  endfunction

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_audio_valid) state_d = S_MUL_L;
      S_MUL_L: state_d = S_MUL_R;
      S_MUL_R: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. i_audio_valid is a strobe with no ready: it is taken only
  // in IDLE; a strobe in any other state is dropped and flagged as overrun.
  always_comb begin
    accept        = 1'b0;
    drop          = 1'b0;
    o_audio_valid = 1'b0;
    case (state_q)
      S_IDLE:  accept = i_audio_valid;
      S_OUT: begin
        o_audio_valid = 1'b1;
        drop          = i_audio_valid;
      end
      default: drop = i_audio_valid;
    endcase
  end

  // Single multiplier shared by both channels; gain is zero-extended so it stays non-negative.
  assign mul_op = (state_q == S_MUL_R) ? r_q : l_q;
  assign g_ext  = {1'b0, g_cap_q};
  assign prod   = PW'(mul_op) * PW'(g_ext);

  // Next applied gain: jump to target when within one step, else move one step toward it.
  always_comb begin
    target = i_mute ? '0 : i_gain;
    g_d    = g_q;
    diff   = '0;
    if (target >= g_q) begin
      diff = target - g_q;
      g_d  = (diff <= STEP_G) ? target : g_q + STEP_G;
    end else begin
      diff = g_q - target;
      g_d  = (diff <= STEP_G) ? target : g_q - STEP_G;
    end
  end

  // Both output registers load on the MUL_R->OUT edge so they change together with the valid strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      l_q       <= '0;
      r_q       <= '0;
      g_cap_q   <= '0;
      g_q       <= '0;
      p_l_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        l_q     <= i_audio_l;
        r_q     <= i_audio_r;
        g_cap_q <= g_q;
      end
      if (state_q == S_MUL_L) p_l_q <= prod;
      if (state_q == S_MUL_R) begin
        out_l_q <= sat(p_l_q);
        out_r_q <= sat(prod);
      end
      if (state_q == S_OUT) g_q <= g_d;
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign o_audio_l   = out_l_q;
  assign o_audio_r   = out_r_q;
  assign o_gain      = g_q;
  assign o_muted     = i_mute && (g_q == '0);
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

`ifdef AUDIO_VOLUME_PEAK_EN
  logic [DATA_BIT-2:0] peak_l_q, peak_r_q;
  logic [DATA_BIT-2:0] abs_l, abs_r;

  // Magnitude of a sample; the most negative value clamps to the largest positive magnitude.
  function automatic logic [DATA_BIT-2:0] abs_mag(input logic [DATA_BIT-1:0] v);
    logic [DATA_BIT-1:0] neg;
    neg = '0;
    if (!v[DATA_BIT-1]) return v[DATA_BIT-2:0];
    if (v[DATA_BIT-2:0] == '0) return '1;
    neg = -v;
    return neg[DATA_BIT-2:0];
  endfunction

  assign abs_l = abs_mag(out_l_q);
  assign abs_r = abs_mag(out_r_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else if (i_peak_clr) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else if (state_q == S_OUT) begin
      if (abs_l > peak_l_q) peak_l_q <= abs_l;
      if (abs_r > peak_r_q) peak_r_q <= abs_r;
    end
  end

  assign o_peak_l = peak_l_q;
  assign o_peak_r = peak_r_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = i_peak_clr;
  assign o_peak_l        = '0;
  assign o_peak_r        = '0;
`endif

endmodule

// File: tb/tb_audio_volume.sv
// Directed bench for audio_volume: a gain/scale model fills an expected queue, outputs are popped and compared.
module tb_audio_volume;
  localparam int DW   = 24;
  localparam int GW   = 8;
  localparam int STEP = 16;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [DW-1:0] i_audio_l = '0;
  logic [DW-1:0] i_audio_r = '0;
  logic          i_audio_valid = 1'b0;
  logic [GW-1:0] i_gain = '0;
  logic          i_mute = 1'b0;
  logic          i_peak_clr = 1'b0;
  logic [DW-1:0] o_audio_l, o_audio_r;
  logic          o_audio_valid;
  logic [GW-1:0] o_gain;
  logic          o_muted, o_overrun;
  logic [DW-2:0] o_peak_l, o_peak_r;
  logic [1:0]    o_dbg_state;

  audio_volume #(.DATA_BIT(DW), .GAIN_BIT(GW), .RAMP_STEP(STEP)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_audio_l(i_audio_l), .i_audio_r(i_audio_r), .i_audio_valid(i_audio_valid),
    .i_gain(i_gain), .i_mute(i_mute), .i_peak_clr(i_peak_clr),
    .o_audio_l(o_audio_l), .o_audio_r(o_audio_r), .o_audio_valid(o_audio_valid),
    .o_gain(o_gain), .o_muted(o_muted), .o_overrun(o_overrun),
    .o_peak_l(o_peak_l), .o_peak_r(o_peak_r), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int g_m = 0;
  logic [DW-2:0] pk_l_m = '0;
  logic [DW-2:0] pk_r_m = '0;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x, input int g);
    longint p, y;
    p = longint'($signed(x)) * longint'(g);
    y = p >>> (GW - 1);
    if (y > 64'sd8388607) y = 64'sd8388607;
    if (y < -64'sd8388608) y = -64'sd8388608;
    return y[DW-1:0];
  endfunction

  function automatic int ramp(input int g, input int t);
    if (t > g) return (t - g <= STEP) ? t : g + STEP;
    if (g > t) return (g - t <= STEP) ? t : g - STEP;
    return g;
  endfunction

  function automatic logic [DW-2:0] mag(input logic [DW-1:0] v);
    longint m;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    if (m > 64'sd8388607) m = 64'sd8388607;
    return m[DW-2:0];
  endfunction

  // Scoreboard: pop one expected pair, compare, advance the gain/peak model, check post-update state.
  task automatic score_out();
    logic [2*DW-1:0] e;
    logic [DW-1:0] el, er;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      el = e[2*DW-1:DW];
      er = e[DW-1:0];
      check("out_l", o_audio_l, el);
      check("out_r", o_audio_r, er);
`ifdef AUDIO_VOLUME_PEAK_EN
      if (mag(el) > pk_l_m) pk_l_m = mag(el);
      if (mag(er) > pk_r_m) pk_r_m = mag(er);
`endif
    end
    g_m = ramp(g_m, i_mute ? 0 : int'(i_gain));
    @(negedge i_clk);
    check("gain", o_gain, g_m);
    check("muted", o_muted, i_mute && (g_m == 0));
    check("peak_l", o_peak_l, pk_l_m);
    check("peak_r", o_peak_r, pk_r_m);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_audio_valid && n < 8);
    check("latency", n, 3);
    score_out();
  endtask

  // Driver: one strobe, expected pair pushed at drive time.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(posedge i_clk); #1;
    i_audio_l     = l;
    i_audio_r     = r;
    i_audio_valid = 1'b1;
    exp_q.push_back({scale(l, g_m), scale(r, g_m)});
    @(posedge i_clk); #1;
    i_audio_valid = 1'b0;
    wait_out();
  endtask

  task automatic ramp_to(input int tgt);
    int guard;
    i_gain = GW'(tgt);
    guard  = 0;
    while (g_m != tgt && guard < 20) begin
      send(DW'($urandom), DW'($urandom));
      guard++;
    end
    check("ramp_reached", g_m, tgt);
  endtask

  task automatic pulse_clr();
    @(posedge i_clk); #1;
    i_peak_clr = 1'b1;
    @(posedge i_clk); #1;
    i_peak_clr = 1'b0;
    pk_l_m = '0;
    pk_r_m = '0;
    @(negedge i_clk);
    check("peak_clr_l", o_peak_l, 0);
    check("peak_clr_r", o_peak_r, 0);
  endtask

  task automatic count_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      if (o_audio_valid) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    // Reset state
    i_gain = 8'd128;
    repeat (3) @(negedge i_clk);
    check("rst_out_l", o_audio_l, 0);
    check("rst_out_r", o_audio_r, 0);
    check("rst_valid", o_audio_valid, 0);
    check("rst_gain", o_gain, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_state", o_dbg_state, 0);
    check("rst_peak_l", o_peak_l, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Ramp up from silence at unity target
    for (int k = 0; k < 9; k++) send(24'h100000, 24'h100000);
    check("unity_gain", o_gain, 128);
    check("unity_out", o_audio_l, 24'h100000);

    // Peak meter at unity gain
    pulse_clr();
    send(24'h000010, 24'h000010);
    send(24'hFFFF00, 24'h000020);
`ifdef AUDIO_VOLUME_PEAK_EN
    check("peak_directed", o_peak_l, 24'h000100);
`else
    check("peak_directed", o_peak_l, 0);
`endif
    pulse_clr();

    // Saturation at max gain
    ramp_to(255);
    send(24'h7FFFFF, 24'h800000);
    check("sat_hi", o_audio_l, 24'h7FFFFF);
    check("sat_lo", o_audio_r, 24'h800000);

    // Floor rounding at half gain
    ramp_to(64);
    send(24'hFFFFFD, 24'h000003);
    check("floor_neg", o_audio_l, 24'hFFFFFE);
    check("floor_pos", o_audio_r, 24'h000001);

    // Random gains and samples, target changed mid-ramp
    for (int k = 0; k < 4; k++) begin
      i_gain = GW'($urandom_range(0, 255));
      for (int j = 0; j < 3; j++) send(DW'($urandom), DW'($urandom));
    end

    // Mute ramp-down and release
    ramp_to(128);
    i_mute = 1'b1;
    #1;
    check("muted_early", o_muted, 0);
    for (int k = 0; k < 8; k++) send(DW'($urandom), DW'($urandom));
    check("mute_gain", o_gain, 0);
    check("mute_flag", o_muted, 1);
    send(24'h123456, 24'h876543);
    check("mute_out", o_audio_l, 0);
    i_mute = 1'b0;
    send(24'h001000, 24'h001000);
    check("unmute_gain", o_gain, 16);

    // Overrun: strobes at cycles 0 and 2
    @(posedge i_clk); #1;
    i_audio_l     = 24'h040000;
    i_audio_r     = 24'hFC0000;
    i_audio_valid = 1'b1;
    exp_q.push_back({scale(24'h040000, g_m), scale(24'hFC0000, g_m)});
    @(posedge i_clk); #1;
    i_audio_valid = 1'b0;
    @(posedge i_clk); #1;
    i_audio_l     = 24'h7FFFFF;
    i_audio_valid = 1'b1;
    @(negedge i_clk);
    check("ovr_before", o_overrun, 0);
    @(posedge i_clk); #1;
    i_audio_valid = 1'b0;
    @(negedge i_clk);
    check("ovr_valid", o_audio_valid, 1);
    check("ovr_flag", o_overrun, 1);
    score_out();
    count_quiet("ovr_no_extra", 8);
    check("ovr_sticky", o_overrun, 1);

    // Reset mid-operation discards the in-flight sample
    @(posedge i_clk); #1;
    i_audio_valid = 1'b1;
    @(posedge i_clk); #1;
    i_audio_valid = 1'b0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check("mid_rst_gain", o_gain, 0);
    check("mid_rst_ovr", o_overrun, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    g_m    = 0;
    pk_l_m = '0;
    pk_r_m = '0;
    count_quiet("mid_rst_no_valid", 6);
    check("mid_rst_state", o_dbg_state, 0);
    send(24'h100000, 24'h100000);
    check("after_rst_out", o_audio_l, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
